// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: FSM state codes and the hex
// segment table ({g,f,e,d,c,b,a}, active-high).
package alu_disp_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] S_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] S_SHOW_HI = 2'd1;
  localparam logic [ST_W-1:0] S_SHOW_LO = 2'd2;
  localparam logic [ST_W-1:0] S_GAP     = 2'd3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/alu_result_display_if.sv
// ALU result valid/ready channel; the producer is master, the display is slave.
interface alu_result_display_if;
  import alu_disp_pkg::*;

  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/alu_result_display_hex_to_seg7.sv
// Combinational nibble to 7-segment pattern decoder.
module hex_to_seg7
  import alu_disp_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/alu_result_display.sv
// Holds the last accepted ALU result and cycles it on a 7-segment digit:
// high nibble (dp lit), low nibble, blank gap. ALU_DISP_ZERO_BLANK_EN skips a zero high digit.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 12_500_000
)(
  input  logic              clk,
  input  logic              rst,
  alu_result_display_if.slave res_if,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic              showing
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

`ifdef ALU_DISP_ZERO_BLANK_EN
  localparam bit ZERO_BLANK = 1'b1;
`else
  localparam bit ZERO_BLANK = 1'b0;
`endif

  logic [ST_W-1:0]   r_state;
  logic [DATA_W-1:0] r_held;
  logic [CNT_W-1:0]  r_cnt;

  logic [ST_W-1:0]   w_state_nxt;
  logic [DATA_W-1:0] w_held_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_enter_hi;
  logic              w_ready;
  logic              w_xfer;
  logic [NIB_W-1:0]  w_nib;
  logic [SEG_W-1:0]  w_seg;

  // Ready depends on state only so the producer sees no valid->ready path.
  assign w_ready          = (r_state == S_IDLE) || (r_state == S_GAP);
  assign w_xfer           = res_if.res_valid & w_ready;
  assign res_if.res_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_held  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_enter_hi  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_xfer) begin
          w_held_nxt = res_if.res_data;
          w_enter_hi = 1'b1;
        end
      end
      S_SHOW_HI: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = S_SHOW_LO;
          w_cnt_nxt   = '0;
        end
      end
      S_SHOW_LO: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        // A new result beats the repeat timeout, even on the last gap cycle.
        if (w_xfer) begin
          w_held_nxt = res_if.res_data;
          w_enter_hi = 1'b1;
        end else if (r_cnt == GAP_LAST) begin
          w_enter_hi = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_enter_hi) begin
      w_cnt_nxt   = '0;
      w_state_nxt = (ZERO_BLANK && (w_held_nxt[7:4] == 4'h0)) ? S_SHOW_LO : S_SHOW_HI;
    end
  end

  assign w_nib = (r_state == S_SHOW_HI) ? r_held[7:4] : r_held[3:0];

  hex_to_seg7 u_hex_to_seg7 (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  assign showing = (r_state == S_SHOW_HI) || (r_state == S_SHOW_LO);
  assign seg     = showing ? w_seg : SEG_BLANK;
  assign dp      = (r_state == S_SHOW_HI);

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Consumer end of the ALU result interface. Accepts 8-bit ALU results over a valid/ready handshake and holds the last accepted result.
- Presents the held result on the single 7-segment output (uo_out) as two time-multiplexed hex digits:
  - high nibble first, decimal point lit;
  - then low nibble;
  - then a blank gap;
  - repeats until a new result is accepted.

Parameters:
- DWELL_CYCLES, 25_000_000, clk cycles each digit is displayed (min 2).
- GAP_CYCLES, 12_500_000, clk cycles of blank between repetitions (min 1).
- CNT_W, $clog2(max(DWELL_CYCLES,GAP_CYCLES)+1), dwell counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- res_data  in  8  ALU result byte.
- res_valid  in  1  producer has a result on res_data.
- res_ready  out  1  block can accept a result this cycle.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0]=a; active-high.
- dp  out  1  decimal point; lit while the high nibble is shown.
- showing  out  1  high in SHOW_HI and SHOW_LO.

Behaviour:
- Reset (async, any state, mid-dwell included):
  - state=IDLE, held=0, counter=0;
  - seg=0, dp=0, showing=0, res_ready=1.
- States: IDLE, SHOW_HI, SHOW_LO, GAP.
- res_ready is high in IDLE and GAP, low in SHOW_HI/SHOW_LO. Combinational from state only; never depends on res_valid.
- Handshake:
  - Transfer occurs at a rising edge with res_valid & res_ready.
  - On that edge: held<=res_data, state<=SHOW_HI, counter<=0.
  - res_valid while res_ready=0 is ignored. The producer holds data and valid until transfer.
- Transitions (counter increments every cycle in SHOW_HI/SHOW_LO/GAP):
  - IDLE: stay until transfer.
  - SHOW_HI: when counter==DWELL_CYCLES-1 -> SHOW_LO, counter<=0.
  - SHOW_LO: when counter==DWELL_CYCLES-1 -> GAP, counter<=0.
  - GAP: transfer takes priority -> SHOW_HI with new held value. Otherwise, when counter==GAP_CYCLES-1 -> SHOW_HI with unchanged held, counter<=0.
- Outputs: combinational decode of registered state and held, no further pipeline. The first segment pattern appears in the cycle after the transfer edge.
  - SHOW_HI: seg=hex(held[7:4]), dp=1.
  - SHOW_LO: seg=hex(held[3:0]), dp=0.
  - IDLE/GAP: seg=0, dp=0.
- Hex table, gfedcba, nibble 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Transfer in the last GAP cycle: the transfer wins; the new value is shown and no stale repeat occurs.
- Counter never wraps. It is compared and cleared on each state change.

Optional Feature:
- Macro: ALU_DISP_ZERO_BLANK_EN.
- Defined: leading-zero suppression.
  - Every entry to SHOW_HI (transfer or GAP timeout) with held[7:4]==0 goes straight to SHOW_LO instead, counter<=0.
  - The high digit and its dp are never shown.
  - held==8'h00 still shows "0" in SHOW_LO.
- Undefined: the high digit is always shown, including 0.

Decomposition:
- Package alu_disp_pkg:
  - state enum (IDLE, SHOW_HI, SHOW_LO, GAP);
  - 16-entry hex segment constant table;
  - SEG_BLANK=7'h00.
- Sub-module hex_to_seg7: 4-bit nibble -> 7-bit pattern, purely combinational, instantiated once on the muxed nibble.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2 in bench):
- Reset, then idle 10 cycles -> seg=0, dp=0, res_ready=1, showing=0 throughout.
- Send 8'h3A -> 4 cycles seg=4F dp=1; 4 cycles seg=77 dp=0; 2 cycles blank with res_ready=1; pattern repeats.
- Hold res_valid with 8'h5C asserted during SHOW_LO -> not accepted until GAP; then 4 cycles seg=6D dp=1.
- Present 8'h01 exactly in the last GAP cycle -> next cycle seg=3F dp=1 (new value), no repeat of the old value.
- Assert rst in cycle 2 of SHOW_LO -> outputs blank immediately (async); res_ready=1; held=0 after release.
- ALU_DISP_ZERO_BLANK_EN defined, send 8'h07 -> 4 cycles seg=07 dp=0, 2 cycles blank, repeat; dp never 1.
